// File: rtl/systolic_4.sv
// systolic_4: 2x2 output-stationary systolic matrix-multiply engine with
// operand/result buffers on a 16-bit register/memory bus.
// Define SYS_ACC32_EN for 32-bit accumulators and results; otherwise 16-bit.
module systolic_4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ren,
    input  logic [15:0] ibus_radr,
    output logic [15:0] ibus_rdata,
    input  logic        wen,
    input  logic [15:0] ibus_wadr,
    input  logic [15:0] ibus_wdata
);
`ifdef SYS_ACC32_EN
    localparam int unsigned AccW = 32;
`else
    localparam int unsigned AccW = 16;
`endif

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // Control tag travelling with each operand wavefront.
    typedef struct packed {
        logic       v;
        logic       first;
        logic       last;
        logic [7:0] r;
    } tag_t;

    state_e      state_q;
    logic [16:0] phase_q;
    logic [15:0] run_q;
    logic [7:0]  idx_q;
    logic [15:0] max_q;
    logic [15:0] runs_q;
    logic        busy;
    logic        feed;
    logic [16:0] last_phase;

    logic [15:0] a0_mem [256];
    logic [15:0] a1_mem [256];
    logic [15:0] b0_mem [256];
    logic [15:0] b1_mem [256];

    // Pipeline: feed stage, PE00 output stage, PE01/PE10 output stage.
    tag_t        ftag, t00, t01;
    logic [15:0] fa0, fb0, da1, db1;
    logic [15:0] a00, b00, fa1, fb1;
    logic [15:0] a10, b01;

    // PE order 0..3 = S00, S10, S01, S11 (matches result address map).
    tag_t            pe_tag [4];
    logic [15:0]     pe_a   [4];
    logic [15:0]     pe_b   [4];
    logic [AccW-1:0] res_rd [4];
    logic [AccW-1:0] res_sel;
    logic [15:0]     rd_mux;

    assign busy       = (state_q == StRun);
    assign last_phase = {1'b0, max_q} + 17'd3;
    assign feed       = busy && (phase_q <= {1'b0, max_q});

    // Run sequencer and bus-programmed control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            run_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            runs_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (wen) begin
                        case (ibus_wadr)
                            16'hFFF0: begin
                                state_q <= StRun;
                                phase_q <= '0;
                                run_q   <= '0;
                                idx_q   <= '0;
                            end
                            16'hFFF1: max_q  <= ibus_wdata;
                            16'hFFF2: runs_q <= ibus_wdata;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    if (feed) idx_q <= idx_q + 8'd1;
                    if (phase_q == last_phase) begin
                        phase_q <= '0;
                        if (run_q == runs_q) state_q <= StIdle;
                        else run_q <= run_q + 16'd1;
                    end else begin
                        phase_q <= phase_q + 17'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Operand buffer writes, blocked while a run is in progress.
    always_ff @(posedge clk) begin
        if (wen && !busy && ibus_wadr[15:10] == 6'd0) begin
            case (ibus_wadr[9:8])
                2'd0: a0_mem[ibus_wadr[7:0]] <= ibus_wdata;
                2'd1: a1_mem[ibus_wadr[7:0]] <= ibus_wdata;
                2'd2: b0_mem[ibus_wadr[7:0]] <= ibus_wdata;
                default: b1_mem[ibus_wadr[7:0]] <= ibus_wdata;
            endcase
        end
    end

    // Operand feed and skew/shift registers between PEs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftag <= '0;
            t00  <= '0;
            t01  <= '0;
            fa0  <= '0;
            fb0  <= '0;
            da1  <= '0;
            db1  <= '0;
            a00  <= '0;
            b00  <= '0;
            fa1  <= '0;
            fb1  <= '0;
            a10  <= '0;
            b01  <= '0;
        end else begin
            ftag.v     <= feed;
            ftag.first <= (phase_q == 17'd0);
            ftag.last  <= (phase_q == {1'b0, max_q});
            ftag.r     <= run_q[7:0];
            fa0        <= a0_mem[idx_q];
            fb0        <= b0_mem[idx_q];
            da1        <= a1_mem[idx_q];
            db1        <= b1_mem[idx_q];
            t00        <= ftag;
            a00        <= fa0;
            b00        <= fb0;
            fa1        <= da1;
            fb1        <= db1;
            t01        <= t00;
            a10        <= fa1;
            b01        <= fb1;
        end
    end

    assign pe_tag[0] = ftag;
    assign pe_a[0]   = fa0;
    assign pe_b[0]   = fb0;
    assign pe_tag[1] = t00;
    assign pe_a[1]   = fa1;
    assign pe_b[1]   = b00;
    assign pe_tag[2] = t00;
    assign pe_a[2]   = a00;
    assign pe_b[2]   = fb1;
    assign pe_tag[3] = t01;
    assign pe_a[3]   = a10;
    assign pe_b[3]   = b01;

    for (genvar g = 0; g < 4; g++) begin : g_pe
        logic [AccW-1:0] acc_q, acc_d, prod;
        logic [AccW-1:0] mem [256];

`ifdef SYS_ACC32_EN
        // Sign-extend so the low 32 bits hold the signed product.
        assign prod = {{16{pe_a[g][15]}}, pe_a[g]} * {{16{pe_b[g][15]}}, pe_b[g]};
`else
        assign prod = pe_a[g] * pe_b[g];
`endif
        assign acc_d     = pe_tag[g].first ? prod : acc_q + prod;
        assign res_rd[g] = mem[ibus_radr[7:0]];

        // Accumulate one term per valid wavefront; first term restarts the sum.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) acc_q <= '0;
            else if (pe_tag[g].v) acc_q <= acc_d;
        end

        // Deposit the finished dot product in the same cycle as its last term.
        always_ff @(posedge clk) begin
            if (pe_tag[g].v && pe_tag[g].last) mem[pe_tag[g].r] <= acc_d;
        end
    end

    assign res_sel = res_rd[ibus_radr[10:9]];

    // Read address decode.
    always_comb begin
        rd_mux = '0;
        if (ibus_radr[15:10] == 6'd0) begin
            case (ibus_radr[9:8])
                2'd0: rd_mux = a0_mem[ibus_radr[7:0]];
                2'd1: rd_mux = a1_mem[ibus_radr[7:0]];
                2'd2: rd_mux = b0_mem[ibus_radr[7:0]];
                default: rd_mux = b1_mem[ibus_radr[7:0]];
            endcase
        end else if (ibus_radr[15:11] == 5'b10000) begin
`ifdef SYS_ACC32_EN
            rd_mux = ibus_radr[8] ? res_sel[31:16] : res_sel[15:0];
`else
            rd_mux = ibus_radr[8] ? 16'h0000 : res_sel;
`endif
        end else begin
            case (ibus_radr)
                16'hFFF0: rd_mux = {15'b0, busy};
                16'hFFF1: rd_mux = max_q;
                16'hFFF2: rd_mux = runs_q;
                default:  rd_mux = '0;
            endcase
        end
    end

    // Registered read data, held while ren is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ibus_rdata <= '0;
        else if (ren) ibus_rdata <= rd_mux;
    end
endmodule

// File: tb/tb_systolic_4.sv
// Testbench for systolic_4: directed bus sequence with a behavioural
// matrix-product model. Follows the SYS_ACC32_EN define of the build.
module tb_systolic_4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ren = 1'b0;
    logic [15:0] ibus_radr = '0;
    logic [15:0] ibus_rdata;
    logic        wen = 1'b0;
    logic [15:0] ibus_wadr = '0;
    logic [15:0] ibus_wdata = '0;

    int n_tests = 0;
    int n_fail = 0;

    // Shadow copy of operand buffers: 0=A0, 1=A1, 2=B0, 3=B1.
    logic [15:0] mdl [4][256];

    systolic_4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ren       (ren),
        .ibus_radr (ibus_radr),
        .ibus_rdata(ibus_rdata),
        .wen       (wen),
        .ibus_wadr (ibus_wadr),
        .ibus_wdata(ibus_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [15:0] adr, input logic [15:0] d);
        wen = 1'b1;
        ibus_wadr = adr;
        ibus_wdata = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] adr, output logic [15:0] d);
        ren = 1'b1;
        ibus_radr = adr;
        @(negedge clk);
        ren = 1'b0;
        d = ibus_rdata;
    endtask

    task automatic load(input int buf_i, input int idx, input logic [15:0] d);
        wr(16'((buf_i << 8) | idx), d);
        mdl[buf_i][idx] = d;
    endtask

    function automatic logic [31:0] golden(input int i, input int j, input int r, input int kmax);
        logic [31:0] s;
        int pa, pb, idx;
        s = '0;
        for (int k = 0; k <= kmax; k++) begin
            idx = (r * (kmax + 1) + k) % 256;
            pa = $signed(mdl[i][idx]);
            pb = $signed(mdl[2 + j][idx]);
            s = s + 32'(pa * pb);
        end
        return s;
    endfunction

    task automatic wait_idle(input int budget, input string tag);
        logic [15:0] d;
        int n;
        n = 0;
        do begin
            rd(16'hFFF0, d);
            n++;
        end while (d[0] && n < budget);
        check(tag, d, 16'h0000);
    endtask

    task automatic check_results(input int kmax, input int runs, input string tag);
        logic [15:0] d, exp_hi;
        logic [31:0] g;
        logic [15:0] base;
        for (int r = 0; r < runs; r++) begin
            for (int j = 0; j < 2; j++) begin
                for (int i = 0; i < 2; i++) begin
                    g = golden(i, j, r, kmax);
                    base = 16'(((32'h40 + i + 2 * j) << 9) | r);
                    rd(base, d);
                    check($sformatf("%s S%0d%0d[%0d] lo", tag, i, j, r), d, g[15:0]);
`ifdef SYS_ACC32_EN
                    exp_hi = g[31:16];
`else
                    exp_hi = 16'h0000;
`endif
                    rd(base | 16'h0100, d);
                    check($sformatf("%s S%0d%0d[%0d] hi", tag, i, j, r), d, exp_hi);
                end
            end
        end
    endtask

    initial begin
        logic [15:0] d, held;

        // Reset state
        repeat (3) @(negedge clk);
        check("rdata at reset", ibus_rdata, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        rd(16'hFFF0, d); check("busy after reset", d, 16'h0000);
        rd(16'hFFF1, d); check("max after reset", d, 16'h0000);
        rd(16'hFFF2, d); check("run after reset", d, 16'h0000);

        // Operand buffer write/readback
        for (int b = 0; b < 4; b++) begin
            for (int n = 0; n < 4; n++) begin
                load(b, (b == 0 ? 0 : 4) + n, 16'(n * 16'h1111));
            end
            for (int n = 0; n < 4; n++) begin
                rd(16'((b << 8) | ((b == 0 ? 0 : 4) + n)), d);
                check($sformatf("buf%0d[%0d]", b, n), d, 16'(n * 16'h1111));
            end
        end
        rd(16'h0400, d); check("unmapped 0x0400", d, 16'h0000);
        held = d;
        rd(16'h0201, d); check("B0[1] readback", d, mdl[2][1]);
        held = d;
        @(negedge clk);
        check("rdata hold", ibus_rdata, held);
        rd(16'hFFF3, d); check("unmapped 0xFFF3", d, 16'h0000);

        // Small directed run: expect 10 in every PE
        for (int n = 0; n < 4; n++) begin
            load(0, n, 16'(n + 1));
            load(1, n, 16'(n + 1));
            load(2, n, 16'h0001);
            load(3, n, 16'h0001);
        end
        wr(16'hFFF1, 16'd3);
        wr(16'hFFF2, 16'd0);
        rd(16'hFFF1, d); check("max readback", d, 16'd3);
        wr(16'hFFF0, 16'h0001);
        rd(16'hFFF0, d); check("busy after start", d, 16'h0001);
        wait_idle(10, "idle small run");
        check_results(3, 1, "small");

        // Randomised four-run product with the most-negative square
        for (int b = 0; b < 4; b++) begin
            for (int n = 0; n < 16; n++) begin
                load(b, n, (n == 0 || n == 5) ? 16'h8000 : 16'($urandom));
            end
        end
        wr(16'hFFF2, 16'd3);
        wr(16'hFFF0, 16'h0001);
        wait_idle(40, "idle rand run");
        check_results(3, 4, "rand");

        // Writes during a run must be ignored
        wr(16'hFFF0, 16'h0001);
        wr(16'hFFF1, 16'd7);
        wr(16'hFFF0, 16'h0001);
        wr(16'h0000, 16'h1234);
        wait_idle(40, "idle busy-write run");
        rd(16'hFFF1, d); check("max unchanged", d, 16'd3);
        rd(16'h0000, d); check("A0[0] unchanged", d, mdl[0][0]);
        check_results(3, 4, "busywr");

        // Mid-run reset then a fresh run with a different shape
        rd(16'h8000, d);
        wr(16'hFFF0, 16'h0001);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rdata on mid-run reset", ibus_rdata, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(16'hFFF0, d); check("busy after abort", d, 16'h0000);
        rd(16'hFFF2, d); check("run after abort", d, 16'h0000);
        wr(16'hFFF1, 16'd1);
        wr(16'hFFF2, 16'd1);
        wr(16'hFFF0, 16'h0001);
        wait_idle(20, "idle after abort run");
        check_results(1, 2, "postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
